// File: rtl/mem_stage_ctrl_pkg.sv
// cpu_pkg: shared MEM-stage types and data width.
package cpu_pkg;
   localparam int DATA_W = 16;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      RD_WAIT = 2'd2,
      DONE    = 2'd3
   } mem_state_t;
endpackage

// File: rtl/mem_stage_ctrl_dff16.sv
// dff_16: 16-bit enabled register with async active-low clear.
module dff_16
   import cpu_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_wen,
   input  logic [DATA_W-1:0] i_d,
   output logic [DATA_W-1:0] o_q
);
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) o_q <= '0;
      else if (i_wen) o_q <= i_d;
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage data-memory handshake, pipeline stall and WB result mux.
module mem_stage_ctrl
   import cpu_pkg::*;
#(
   parameter int TIMEOUT = 64
)
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_mem_read,
   input  logic              i_mem_write,
   input  logic              i_mem_to_reg,
   input  logic              i_pcs,
   input  logic [DATA_W-1:0] i_alu_out,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [DATA_W-1:0] i_pc,
   output logic              o_dmem_req,
   output logic              o_dmem_we,
   output logic [DATA_W-1:0] o_dmem_addr,
   output logic [DATA_W-1:0] o_dmem_wdata,
   input  logic              i_dmem_ready,
   input  logic              i_dmem_rvalid,
   input  logic [DATA_W-1:0] i_dmem_rdata,
   output logic              o_stall_mem,
   output logic [DATA_W-1:0] o_wb_data,
   output logic              o_mem_err
);
   localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WD_W-1:0] WD_MAX = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   mem_state_t r_state;
   mem_state_t w_next;
   logic [WD_W-1:0] r_wdog;
   logic r_err;
   logic w_acc, w_we, w_idle, w_busy, w_prog, w_abort, w_ld_wen;
   logic [DATA_W-1:0] w_ld_data;
   assign w_acc  = i_mem_read | i_mem_write;
   assign w_we   = i_mem_write & ~i_mem_read;
   assign w_idle = (r_state == IDLE);
   assign w_busy = (r_state == REQ) | (r_state == RD_WAIT);
   assign w_prog = (r_state == REQ) ? i_dmem_ready : i_dmem_rvalid;
   // >= so a read accepted on the last allowed REQ cycle still times out in RD_WAIT
   assign w_abort = (TIMEOUT > 0) && w_busy && !w_prog && (r_wdog >= WD_MAX);
   assign w_ld_wen = ((r_state == RD_WAIT) & i_dmem_rvalid) | w_abort;
   always_comb
      w_next = w_abort ? DONE :
               w_idle ? (i_mem_read ? (i_dmem_ready ? RD_WAIT : REQ) :
                         (i_mem_write & ~i_dmem_ready) ? REQ : IDLE) :
               (r_state == REQ) ? (i_dmem_ready ? (i_mem_read ? RD_WAIT : DONE) : REQ) :
               (r_state == RD_WAIT) ? (i_dmem_rvalid ? DONE : RD_WAIT) : IDLE;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_wdog  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_wdog  <= w_busy ? r_wdog + 1'b1 : '0;
         r_err   <= r_err | w_abort;
      end
   dff_16 u_ld_data (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_wen   (w_ld_wen),
      .i_d     (w_abort ? '0 : i_dmem_rdata),
      .o_q     (w_ld_data)
   );
   // reset gating makes req/stall drop the instant reset asserts
   assign o_dmem_req   = i_rst_n & ((w_idle & w_acc) | (r_state == REQ));
   assign o_dmem_we    = w_we;
   assign o_dmem_addr  = i_alu_out;
   assign o_dmem_wdata = i_wdata;
   assign o_stall_mem  = i_rst_n & (w_busy | (w_idle & w_acc & ~(w_we & i_dmem_ready)));
   assign o_wb_data    = i_mem_to_reg ? w_ld_data : i_pcs ? i_pc : i_alu_out;
   assign o_mem_err    = r_err;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed and random transactions checked against a transaction-level model.
module tb_mem_stage_ctrl;
   localparam int TO = 8;
   logic clk = 1'b0, rst_n = 1'b0;
   logic mem_read = 1'b0, mem_write = 1'b0, mem_to_reg = 1'b0, pcs = 1'b0;
   logic dmem_ready = 1'b0, dmem_rvalid = 1'b0;
   logic [15:0] alu_out = '0, wdata = '0, pc = '0, dmem_rdata = '0;
   logic dmem_req, dmem_we, stall_mem, mem_err;
   logic [15:0] dmem_addr, dmem_wdata, wb_data;
   int errors = 0, checks = 0;
   logic [15:0] m_ld = '0;
   logic m_err = 1'b0;
   always #5 clk = ~clk;
   mem_stage_ctrl #(.TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_mem_read(mem_read), .i_mem_write(mem_write), .i_mem_to_reg(mem_to_reg), .i_pcs(pcs),
      .i_alu_out(alu_out), .i_wdata(wdata), .i_pc(pc),
      .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata),
      .i_dmem_ready(dmem_ready), .i_dmem_rvalid(dmem_rvalid), .i_dmem_rdata(dmem_rdata),
      .o_stall_mem(stall_mem), .o_wb_data(wb_data), .o_mem_err(mem_err)
   );
   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask
   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask
   // One EX/MEM instruction: ready arrives d cycles after issue, rvalid r cycles after acceptance.
   task automatic txn(input logic rd, input logic wr, input logic m2r, input logic ps,
                      input int d, input int r, input logic to,
                      input logic [15:0] a, input logic [15:0] wd, input logic [15:0] rv, input logic [15:0] pcv);
      int last, acc_n;
      logic acc;
      acc = rd | wr;
      acc_n = 0;
      last = !acc ? 0 : rd ? (to ? TO + 1 : d + r + 1) : (d == 0 ? 0 : d + 1);
      for (int k = 0; k <= last; k++) begin
         mem_read = rd; mem_write = wr; mem_to_reg = m2r; pcs = ps;
         alu_out = a; wdata = wd; pc = pcv;
         dmem_ready = acc ? (k == d) : 1'($urandom_range(0, 1));
         dmem_rvalid = (rd && !to && k == d + r) || (k <= d && 1'($urandom_range(0, 1)));
         dmem_rdata = (rd && k == d + r) ? rv : 16'($urandom);
         if (rd && k == last) m_ld = to ? 16'h0 : rv;
         if (to && k == last) m_err = 1'b1;
         #1;
         if (dmem_req && dmem_ready) acc_n++;
         chk1("stall", stall_mem, acc && k < last);
         chk1("req", dmem_req, acc && k <= d);
         chk1("we", dmem_we, wr && !rd);
         chk16("addr", dmem_addr, a);
         chk16("wdata", dmem_wdata, wd);
         chk16("wb_data", wb_data, m2r ? m_ld : ps ? pcv : a);
         chk1("mem_err", mem_err, m_err);
         next_cycle();
      end
      chk16("accepts", 16'(acc_n), {15'd0, acc});
   endtask
   initial begin
      mem_read = 1'b1; mem_to_reg = 1'b1;
      #2;
      chk1("rst_req", dmem_req, 1'b0);
      chk1("rst_stall", stall_mem, 1'b0);
      chk1("rst_err", mem_err, 1'b0);
      chk16("rst_wb", wb_data, 16'h0);
      next_cycle();
      mem_read = 1'b0;
      rst_n = 1'b1;
      next_cycle();
      txn(1, 0, 1, 0, 0, 1, 0, 16'h0040, 16'h0000, 16'hBEEF, 16'h0010);
      txn(0, 1, 0, 0, 0, 1, 0, 16'h0200, 16'hCAFE, 16'h0000, 16'h0012);
      txn(0, 0, 1, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0014);
      txn(0, 1, 0, 0, 3, 1, 0, 16'h0300, 16'h5A5A, 16'h0000, 16'h0016);
      txn(1, 1, 1, 0, 1, 2, 0, 16'h0400, 16'h1111, 16'h7E57, 16'h0018);
      txn(0, 0, 0, 1, 0, 1, 0, 16'h0999, 16'h0000, 16'h0000, 16'h0102);
      txn(1, 0, 1, 0, 0, 1, 1, 16'h0500, 16'h0000, 16'hDEAD, 16'h001A);
      txn(0, 0, 1, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h001C);
      mem_read = 1'b1; mem_write = 1'b0; mem_to_reg = 1'b1; pcs = 1'b0;
      alu_out = 16'h0080; dmem_ready = 1'b1; dmem_rvalid = 1'b0;
      next_cycle();
      dmem_ready = 1'b0;
      next_cycle();
      chk1("rd_wait_stall", stall_mem, 1'b1);
      rst_n = 1'b0;
      m_ld = 16'h0;
      m_err = 1'b0;
      #1;
      chk1("async_req", dmem_req, 1'b0);
      chk1("async_stall", stall_mem, 1'b0);
      chk1("async_err", mem_err, 1'b0);
      mem_read = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      dmem_rvalid = 1'b1;
      dmem_rdata = 16'h1234;
      #1;
      chk1("stale_stall", stall_mem, 1'b0);
      chk16("stale_wb", wb_data, 16'h0);
      next_cycle();
      dmem_rvalid = 1'b0;
      #1;
      chk1("post_stall", stall_mem, 1'b0);
      chk16("post_wb", wb_data, 16'h0);
      next_cycle();
      for (int i = 0; i < 40; i++) begin
         int kind;
         kind = int'($urandom_range(0, 3));
         txn(kind == 1 || kind == 3, kind >= 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), 1'b0,
             16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
